// File: rtl/sha_uart_ctrl_if.sv
// Bundles the block-input, SHA-core and UART-TX signals of sha_uart_ctrl.
// The master modport is the environment side, and the slave modport is the controller side.
interface sha_uart_ctrl_if;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         core_ready;
  logic         core_digest_valid;
  logic [255:0] core_digest;
  logic         tx_done;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic         tx_start;
  logic [7:0]   tx_byte;
  logic         busy;
  logic         err_overrun;

  modport master (
    output blk_valid, blk_data, blk_last, core_ready, core_digest_valid, core_digest, tx_done,
    input  core_init, core_next, core_block, tx_start, tx_byte, busy, err_overrun
  );

  modport slave (
    input  blk_valid, blk_data, blk_last, core_ready, core_digest_valid, core_digest, tx_done,
    output core_init, core_next, core_block, tx_start, tx_byte, busy, err_overrun
  );
endinterface

// File: rtl/sha_uart_ctrl.sv
// Feeds 512-bit blocks to a SHA-256 core and streams the final digest out over a UART TX.
// Define SHA_UART_CTRL_HEX_EN to send 64 lowercase hex characters plus CR LF instead of 32 raw bytes.
module sha_uart_ctrl (
  input  logic           clk,
  input  logic           rst,
  sha_uart_ctrl_if.slave bus
);
`ifdef SHA_UART_CTRL_HEX_EN
  localparam int unsigned NumBytes = 66;
  localparam int unsigned CntW     = 7;
`else
  localparam int unsigned NumBytes = 32;
  localparam int unsigned CntW     = 5;
`endif
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StTxLoad, StTxWait} state_e;

  state_e            r_state;
  logic              r_first;
  logic              r_last;
  logic [CntW-1:0]   r_byte_cnt;
  logic [255:0]      r_digest;
  logic [511:0]      r_block;
  logic              r_init;
  logic              r_next;
  logic              r_tx_start;
  logic [7:0]        r_tx_byte;
  logic              r_err;
  logic [7:0]        w_byte;

`ifdef SHA_UART_CTRL_HEX_EN
  logic [3:0] w_nib;
  always_comb begin
    w_nib = r_digest[{~r_byte_cnt[5:0], 2'b00} +: 4];
    if (r_byte_cnt == 7'd64)      w_byte = 8'h0d;
    else if (r_byte_cnt == 7'd65) w_byte = 8'h0a;
    else if (w_nib < 4'd10)       w_byte = 8'h30 + {4'h0, w_nib};
    else                          w_byte = 8'h57 + {4'h0, w_nib};
  end
`else
  // ~cnt selects byte (31 - cnt), so byte 0 is digest[255:248]
  always_comb begin
    w_byte = r_digest[{~r_byte_cnt, 3'b000} +: 8];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_first    <= 1'b1;
      r_last     <= 1'b0;
      r_byte_cnt <= '0;
      r_digest   <= '0;
      r_block    <= '0;
      r_init     <= 1'b0;
      r_next     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_byte  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_init     <= 1'b0;
      r_next     <= 1'b0;
      r_tx_start <= 1'b0;
      if (bus.blk_valid && (r_state != StIdle)) r_err <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (bus.blk_valid) begin
            r_block <= bus.blk_data;
            r_last  <= bus.blk_last;
            r_state <= StIssue;
            // A ready core gets its command in the first ISSUE cycle
            if (bus.core_ready) begin
              r_init  <= r_first;
              r_next  <= ~r_first;
              r_first <= 1'b0;
            end
          end
        end
        StIssue: begin
          if (r_init || r_next) begin
            r_state <= StWait;
          end else if (bus.core_ready) begin
            r_init  <= r_first;
            r_next  <= ~r_first;
            r_first <= 1'b0;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (bus.core_digest_valid) begin
            if (r_last) begin
              r_digest   <= bus.core_digest;
              r_byte_cnt <= '0;
              r_state    <= StTxLoad;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StTxLoad: begin
          r_tx_byte  <= w_byte;
          r_tx_start <= 1'b1;
          r_state    <= StTxWait;
        end
        StTxWait: begin
          if (bus.tx_done) begin
            if (r_byte_cnt == LastCnt) begin
              r_byte_cnt <= '0;
              r_first    <= 1'b1;
              r_state    <= StIdle;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_state    <= StTxLoad;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.core_init   = r_init;
  assign bus.core_next   = r_next;
  assign bus.core_block  = r_block;
  assign bus.tx_start    = r_tx_start;
  assign bus.tx_byte     = r_tx_byte;
  assign bus.busy        = (r_state != StIdle);
  assign bus.err_overrun = r_err;
endmodule

// File: tb/tb_sha_uart_ctrl.sv
// Directed bench for sha_uart_ctrl, with a mock SHA core and a mock UART TX.
// Stimulus is driven on negedge, and the mocks drive and sample one time unit after each posedge.
module tb_sha_uart_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_uart_ctrl_if bus_if ();
  sha_uart_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if.slave));

`ifdef SHA_UART_CTRL_HEX_EN
  localparam int NBytes = 66;
  localparam logic [7:0] Byte0 = 8'h62;  // 'b'
  localparam logic [7:0] Byte1 = 8'h61;  // 'a'
`else
  localparam int NBytes = 32;
  localparam logic [7:0] Byte0 = 8'hba;
  localparam logic [7:0] Byte1 = 8'h78;
`endif

  localparam logic [255:0] DigAbc =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DigMid =
    256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [255:0] DigAlt =
    256'hc0ffee00deadbeef1122334455667788a5a55a5a0000ffff9999aaaa12345678;
  localparam logic [511:0] BlkAbc = {32'h61626380, 416'h0, 64'h18};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_init, n_next, n_start, n_gap_bad;
  int n_both = 0;
  int n_overlap = 0;
  int core_wait, tx_wait, cyc_cmd, cyc_done;
  bit tx_out, gap_pend;
  logic [255:0] mock_digest;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Mock core (4-cycle hash) and mock UART (3 cycles per byte)
  initial begin
    bus_if.core_digest_valid = 1'b0;
    bus_if.core_digest = '0;
    bus_if.tx_done = 1'b0;
    core_wait = 0; tx_wait = 0; tx_out = 0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.core_digest_valid = 1'b0;
      bus_if.tx_done = 1'b0;
      if (rst) begin
        core_wait = 0; tx_wait = 0; tx_out = 0;
      end else begin
        if (bus_if.core_init && bus_if.core_next) n_both++;
        if (bus_if.core_init || bus_if.core_next) begin
          if (bus_if.core_init) n_init++;
          else n_next++;
          cyc_cmd = cyc;
          core_wait = 4;
        end else if (core_wait > 0) begin
          core_wait--;
          if (core_wait == 0) begin
            bus_if.core_digest_valid = 1'b1;
            bus_if.core_digest = mock_digest;
          end
        end
        if (bus_if.tx_start) begin
          n_start++;
          if (tx_out) n_overlap++;
          if (gap_pend && (cyc - cyc_done != 2)) n_gap_bad++;
          gap_pend = 0;
          got.push_back(bus_if.tx_byte);
          tx_out = 1;
          tx_wait = 3;
        end else if (tx_wait > 0) begin
          tx_wait--;
          if (tx_wait == 0) begin
            bus_if.tx_done = 1'b1;
            tx_out = 0;
            cyc_done = cyc;
            gap_pend = 1;
          end
        end
      end
    end
  end

  task automatic clear_counts();
    n_init = 0; n_next = 0; n_start = 0; n_gap_bad = 0; gap_pend = 0;
    got.delete();
  endtask

  task automatic build_exp(input logic [255:0] d);
    logic [3:0] nib;
    exp_q.delete();
`ifdef SHA_UART_CTRL_HEX_EN
    for (int i = 0; i < 64; i++) begin
      nib = d[255 - 4*i -: 4];
      exp_q.push_back((nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib});
    end
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
`else
    for (int i = 0; i < 32; i++) exp_q.push_back(d[255 - 8*i -: 8]);
`endif
  endtask

  task automatic cmp_stream(input string tag, input logic [255:0] d);
    int mism;
    build_exp(d);
    chk({tag, "_len"}, 512'(got.size()), 512'(NBytes));
    mism = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) mism++;
    chk({tag, "_bytes"}, 512'(mism), 512'(0));
  endtask

  int cyc_blk;
  task automatic send(input logic [511:0] d, input logic last);
    @(negedge clk);
    bus_if.blk_valid = 1'b1;
    bus_if.blk_data = d;
    bus_if.blk_last = last;
    cyc_blk = cyc;
    @(negedge clk);
    bus_if.blk_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 2000 && bus_if.busy; k++) @(negedge clk);
    chk(tag, 512'(bus_if.busy), 512'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_init"}, 512'(bus_if.core_init), 512'(0));
    chk({tag, "_next"}, 512'(bus_if.core_next), 512'(0));
    chk({tag, "_start"}, 512'(bus_if.tx_start), 512'(0));
    chk({tag, "_busy"}, 512'(bus_if.busy), 512'(0));
    chk({tag, "_err"}, 512'(bus_if.err_overrun), 512'(0));
    chk({tag, "_block"}, bus_if.core_block, 512'(0));
    chk({tag, "_txbyte"}, 512'(bus_if.tx_byte), 512'(0));
  endtask

  initial begin
    int cmd_bad, blk_bad, cyc_rdy;
    bus_if.blk_valid = 1'b0;
    bus_if.blk_data = '0;
    bus_if.blk_last = 1'b0;
    bus_if.core_ready = 1'b1;
    mock_digest = DigAbc;
    clear_counts();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Single "abc" block
    clear_counts();
    send(BlkAbc, 1'b1);
    chk("abc_block", bus_if.core_block, BlkAbc);
    wait_idle("abc_idle");
    chk("abc_lat", 512'(cyc_cmd - cyc_blk), 512'(1));
    chk("abc_ninit", 512'(n_init), 512'(1));
    chk("abc_nnext", 512'(n_next), 512'(0));
    chk("abc_b0", 512'((got.size() > 0) ? got[0] : 8'hxx), 512'(Byte0));
    chk("abc_b1", 512'((got.size() > 1) ? got[1] : 8'hxx), 512'(Byte1));
    chk("abc_gap", 512'(n_gap_bad), 512'(0));
    cmp_stream("abc", DigAbc);

    // Two-block message
    clear_counts();
    mock_digest = DigMid;
    send({16{32'h5a5a0f0f}}, 1'b0);
    wait_idle("two_idle1");
    chk("two_nostart", 512'(n_start), 512'(0));
    mock_digest = DigAlt;
    send({16{32'h13579bdf}}, 1'b1);
    wait_idle("two_idle2");
    chk("two_ninit", 512'(n_init), 512'(1));
    chk("two_nnext", 512'(n_next), 512'(1));
    cmp_stream("two", DigAlt);

    // Core not ready for 10+ cycles
    clear_counts();
    mock_digest = DigMid;
    bus_if.core_ready = 1'b0;
    send({8{64'hfeedface01020304}}, 1'b1);
    cmd_bad = 0; blk_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (n_init + n_next != 0) cmd_bad++;
      if (bus_if.core_block !== {8{64'hfeedface01020304}}) blk_bad++;
    end
    chk("rdy_nocmd", 512'(cmd_bad), 512'(0));
    chk("rdy_block", 512'(blk_bad), 512'(0));
    bus_if.core_ready = 1'b1;
    cyc_rdy = cyc;
    for (int k = 0; k < 50 && (n_init + n_next) == 0; k++) @(negedge clk);
    chk("rdy_lat", 512'(cyc_cmd - cyc_rdy), 512'(1));
    chk("rdy_ninit", 512'(n_init), 512'(1));
    wait_idle("rdy_idle");
    cmp_stream("rdy", DigMid);

    // Overruns during WAIT and during TX_WAIT
    clear_counts();
    mock_digest = DigAbc;
    send(BlkAbc, 1'b1);
    @(negedge clk);
    bus_if.blk_valid = 1'b1;
    bus_if.blk_data = '1;
    bus_if.blk_last = 1'b0;
    @(negedge clk);
    bus_if.blk_valid = 1'b0;
    chk("ovr_err1", 512'(bus_if.err_overrun), 512'(1));
    chk("ovr_block1", bus_if.core_block, BlkAbc);
    for (int k = 0; k < 50 && !bus_if.tx_start; k++) @(negedge clk);
    bus_if.blk_valid = 1'b1;
    @(negedge clk);
    bus_if.blk_valid = 1'b0;
    chk("ovr_busy", 512'(bus_if.busy), 512'(1));
    chk("ovr_block2", bus_if.core_block, BlkAbc);
    wait_idle("ovr_idle");
    chk("ovr_err2", 512'(bus_if.err_overrun), 512'(1));
    chk("ovr_ninit", 512'(n_init + n_next), 512'(1));
    cmp_stream("ovr", DigAbc);

    // Reset mid-stream
    clear_counts();
    send(BlkAbc, 1'b1);
    for (int k = 0; k < 500 && got.size() < 6; k++) @(negedge clk);
    chk("rst_reach", 512'(got.size() >= 6), 512'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("rstmid");
    clear_counts();
    send(BlkAbc, 1'b1);
    wait_idle("rst_idle");
    chk("rst_ninit", 512'(n_init), 512'(1));
    chk("rst_nnext", 512'(n_next), 512'(0));
    cmp_stream("rst", DigAbc);

    chk("no_both", 512'(n_both), 512'(0));
    chk("no_overlap", 512'(n_overlap), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
